entrada_jogadores: RTL
======================

// Module: entrada_jogadores
// PURPOSE
//   Input conditioner feeding the player/arena logic: synchronises and debounces the four
//   active-low push buttons and turns each press into a quarter-turn request per player.
//   Each player holds at most one pending turn, applied only on the game step strobe 'tick'.
//   A player therefore turns at most 90 degrees per step (no 180-degree self-collision), and
//   a press between steps is never lost. Outputs the current heading of both players.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  stable cycles required to accept a key level (10 ms @ 50 MHz)
//   CNT_W            20      debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//   CLOCK_50       in   1  system clock, all logic on rising edge
//   reset          in   1  synchronous, active-high reset
//   KEY            in   4  raw buttons, active-low: [3] J1 anti-clockwise, [2] J1 clockwise,
//                          [1] J2 anti-clockwise, [0] J2 clockwise
//   tick           in   1  one-cycle movement step strobe from game logic
//   habilita       in   1  1 = game running; 0 = game over, requests ignored and cleared
//   sentido_j1     out  2  J1 heading: 0 right, 1 down, 2 left, 3 up
//   sentido_j2     out  2  J2 heading, same encoding
//   giro_pendente  out  2  [1] J1 / [0] J2 has a pending turn
//   tecla_pulso    out  4  one-cycle debounced press pulse per KEY bit (debug/other consumers)
// BEHAVIOUR
//   Reset values: sync flops and stable levels = 1 (released), debounce counters = 0,
//     tecla_pulso = 0, giro_pendente = 0, pending states = IDLE,
//     sentido_j1 = 0 (right), sentido_j2 = 2 (left).
//   Reset is honoured mid-debounce and mid-pending: all of the above are restored the next cycle.
//   Synchroniser: 2-flop per KEY bit; downstream logic uses only the synchronised value.
//   Debounce per bit: if sync == stable, counter <= 0. Otherwise counter increments; when
//     counter == DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0. A glitch shorter than
//     DEBOUNCE_CYCLES cycles never changes stable.
//   tecla_pulso[i] = 1 for exactly one cycle, the cycle after stable[i] goes 1->0;
//     release generates nothing. Latency from KEY edge to pulse: 2 + DEBOUNCE_CYCLES cycles.
//   Per-player FSM, states IDLE, PEND_AH, PEND_H:
//     IDLE    + AH pulse only  -> PEND_AH
//     IDLE    + H pulse only   -> PEND_H
//     IDLE    + AH and H in same cycle -> stay IDLE (both dropped)
//     PEND_*  + any pulse, no tick -> unchanged (first request wins, later ones dropped)
//     PEND_AH + tick -> sentido <= sentido - 1 (mod 4), state IDLE
//     PEND_H  + tick -> sentido <= sentido + 1 (mod 4), state IDLE
//     tick with a valid single pulse in the same cycle: pending turn (if any) is applied, the
//       new pulse is latched as the next pending state; from IDLE it is latched only, never
//       applied in that cycle. tick in IDLE with no pulse: no change.
//   habilita = 0: both FSMs forced to IDLE, pulses ignored, sentido held; tick has no effect.
//   Heading arithmetic is 2-bit wrap-around: 0-1 = 3, 3+1 = 0.
//   giro_pendente[k] = 1 exactly while player k's FSM is not IDLE. All outputs registered.
// TESTING (bench uses DEBOUNCE_CYCLES = 4)
//   1. Reset released, no keys -> sentido_j1=0, sentido_j2=2, giro_pendente=0, tecla_pulso=0.
//   2. KEY[2] low for 2 cycles then high -> no tecla_pulso, sentido_j1 stays 0.
//   3. KEY[2] held low 20 cycles -> tecla_pulso[2] one cycle, 6 cycles after the edge;
//      giro_pendente[1]=1; next tick -> sentido_j1=1, giro_pendente[1]=0.
//   4. J2 (heading 2): KEY[1] then KEY[0] pressed before a tick -> after tick sentido_j2=1
//      (second request dropped); from heading 0, KEY[3] press + tick -> 3 (wrap).
//   5. Press KEY[3] valid in same cycle as tick while IDLE -> sentido_j1 unchanged that tick,
//      giro_pendente[1]=1, applied on the following tick.
//   6. Pending J1 turn, habilita=0 then tick -> giro_pendente=0, sentido unchanged; assert
//      reset during pending turn -> headings return to 0 and 2 the next cycle.

Source files
------------

// File: rtl/entrada_jogadores.sv
// Player input conditioner: synchronises and debounces the four active-low buttons and turns
// each debounced press into at most one pending quarter-turn per player, applied on 'tick'.
`timescale 1ns/1ps
module entrada_jogadores #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic       tick,
    input  logic       habilita,
    output logic [1:0] sentido_j1,
    output logic [1:0] sentido_j2,
    output logic [1:0] giro_pendente,
    output logic [3:0] tecla_pulso
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_AH = 2'd1,
        PEND_H  = 2'd2
    } estado_t;

    logic [3:0]       key_s1;
    logic [3:0]       key_s2;
    logic [3:0]       estavel;
    logic [CNT_W-1:0] cnt [4];

    estado_t    estado_j1, estado_j2;
    estado_t    prox_j1, prox_j2;
    logic [1:0] prox_sent_j1, prox_sent_j2;

    // Synchroniser, per-bit debounce and press pulse (issued together with the 1->0 update)
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_s1      <= 4'hF;
            key_s2      <= 4'hF;
            estavel     <= 4'hF;
            tecla_pulso <= 4'h0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            key_s1      <= KEY;
            key_s2      <= key_s1;
            tecla_pulso <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] == estavel[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    estavel[i]     <= key_s2[i];
                    cnt[i]         <= '0;
                    tecla_pulso[i] <= estavel[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A request is accepted only when exactly one direction was pressed
    function automatic estado_t pedido(input logic ah, input logic h);
        estado_t r;
        r = IDLE;
        if (ah && !h) r = PEND_AH;
        else if (h && !ah) r = PEND_H;
        return r;
    endfunction

    function automatic logic [1:0] girar(input estado_t e, input logic [1:0] s);
        logic [1:0] r;
        case (e)
            PEND_AH: r = s - 2'd1;
            PEND_H:  r = s + 2'd1;
            default: r = s;
        endcase
        return r;
    endfunction

    // Next state: apply pending turn on tick, latch a new request when free or on tick
    always_comb begin
        prox_j1      = estado_j1;
        prox_j2      = estado_j2;
        prox_sent_j1 = sentido_j1;
        prox_sent_j2 = sentido_j2;
        if (!habilita) begin
            prox_j1 = IDLE;
            prox_j2 = IDLE;
        end else begin
            if (tick) begin
                prox_sent_j1 = girar(estado_j1, sentido_j1);
                prox_sent_j2 = girar(estado_j2, sentido_j2);
            end
            if (tick || estado_j1 == IDLE) prox_j1 = pedido(tecla_pulso[3], tecla_pulso[2]);
            if (tick || estado_j2 == IDLE) prox_j2 = pedido(tecla_pulso[1], tecla_pulso[0]);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            estado_j1     <= IDLE;
            estado_j2     <= IDLE;
            sentido_j1    <= 2'd0;
            sentido_j2    <= 2'd2;
            giro_pendente <= 2'b00;
        end else begin
            estado_j1     <= prox_j1;
            estado_j2     <= prox_j2;
            sentido_j1    <= prox_sent_j1;
            sentido_j2    <= prox_sent_j2;
            giro_pendente <= {prox_j1 != IDLE, prox_j2 != IDLE};
        end
    end

endmodule
